// File: rtl/npc_ras.sv
// Registered PC unit with next-PC selection and a circular return-address stack.
// Redirect overrides everything; stall freezes PC and RAS; CALL pushes PC+4, RET pops.
module npc_ras #(
  parameter int               WIDTH     = 32,
  parameter logic [WIDTH-1:0] RESET_PC  = '0,
  parameter int               RAS_DEPTH = 4
) (
  input  logic             clk,
  input  logic             rstn,
  input  logic             stall,
  input  logic             redirect,
  input  logic [WIDTH-1:0] redirect_pc,
  input  logic [2:0]       NPCOp,
  input  logic [25:0]      IMM,
  input  logic [WIDTH-1:0] RS_VAL,
  output logic [WIDTH-1:0] PC,
  output logic [WIDTH-1:0] PCPLUS4,
  output logic [WIDTH-1:0] NPC,
  output logic             ras_empty,
  output logic             ras_full
);

  localparam int PTR_W = $clog2(RAS_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [2:0] OP_PLUS4  = 3'b000;
  localparam logic [2:0] OP_BRANCH = 3'b001;
  localparam logic [2:0] OP_JUMP   = 3'b010;
  localparam logic [2:0] OP_JR     = 3'b011;
  localparam logic [2:0] OP_CALL   = 3'b100;
  localparam logic [2:0] OP_RET    = 3'b101;

  logic [WIDTH-1:0] pc_q, pc_d;
  logic [PTR_W-1:0] ptr_q, ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] ras_q [RAS_DEPTH];
  logic [WIDTH-1:0] ras_d [RAS_DEPTH];

  logic [WIDTH-1:0] branch_off;
  logic [WIDTH-1:0] jump_tgt;
  logic [WIDTH-1:0] op_npc;
  logic [PTR_W-1:0] ptr_inc;

  assign PC         = pc_q;
  assign PCPLUS4    = pc_q + WIDTH'(4);
  assign branch_off = {{(WIDTH-18){IMM[15]}}, IMM[15:0], 2'b00};
  assign ras_empty  = (cnt_q == '0);
  assign ras_full   = (cnt_q == CNT_W'(RAS_DEPTH));
  assign ptr_inc    = ptr_q + PTR_W'(1);

  // Jump keeps the upper PC+4 bits and replaces the low 28 with IMM<<2.
  always_comb begin
    jump_tgt       = PCPLUS4;
    jump_tgt[27:0] = {IMM, 2'b00};
  end

  always_comb begin
    op_npc = PCPLUS4;
    case (NPCOp)
      OP_BRANCH: op_npc = PCPLUS4 + branch_off;
      OP_JUMP:   op_npc = jump_tgt;
      OP_JR:     op_npc = RS_VAL;
      OP_CALL:   op_npc = jump_tgt;
      OP_RET:    op_npc = ras_empty ? RS_VAL : ras_q[ptr_q];
      default:   op_npc = PCPLUS4;
    endcase
  end

  assign NPC = redirect ? redirect_pc : op_npc;

  // A push always advances the pointer; when full it lands on the oldest entry.
  always_comb begin
    pc_d  = pc_q;
    ptr_d = ptr_q;
    cnt_d = cnt_q;
    ras_d = ras_q;
    if (redirect) begin
      pc_d = redirect_pc;
    end else if (!stall) begin
      pc_d = NPC;
      case (NPCOp)
        OP_CALL: begin
          ptr_d          = ptr_inc;
          ras_d[ptr_inc] = PCPLUS4;
          if (!ras_full) cnt_d = cnt_q + CNT_W'(1);
        end
        OP_RET: begin
          if (!ras_empty) begin
            ptr_d = ptr_q - PTR_W'(1);
            cnt_d = cnt_q - CNT_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      pc_q  <= RESET_PC;
      ptr_q <= '0;
      cnt_q <= '0;
      for (int i = 0; i < RAS_DEPTH; i++) ras_q[i] <= '0;
    end else begin
      pc_q  <= pc_d;
      ptr_q <= ptr_d;
      cnt_q <= cnt_d;
      ras_q <= ras_d;
    end
  end

endmodule

// File: tb/tb_npc_ras.sv
// Bench for npc_ras: directed scenarios with literal expectations, then random
// traffic checked every cycle against a queue-based return-stack model.
module tb_npc_ras;
  localparam int          W     = 32;
  localparam int          DEPTH = 4;
  localparam logic [31:0] RPC   = 32'h0040_0000;

  logic          clk;
  logic          rstn;
  logic          stall;
  logic          redirect;
  logic [W-1:0]  redirect_pc;
  logic [2:0]    npc_op;
  logic [25:0]   imm;
  logic [W-1:0]  rs_val;
  logic [W-1:0]  pc;
  logic [W-1:0]  pcplus4;
  logic [W-1:0]  npc;
  logic          ras_empty;
  logic          ras_full;

  int n_chk  = 0;
  int n_fail = 0;

  // Model state: architectural PC and return addresses, newest at the back.
  logic [W-1:0] pc_m = RPC;
  logic [W-1:0] exp_q[$];

  npc_ras #(.WIDTH(W), .RESET_PC(RPC), .RAS_DEPTH(DEPTH)) dut (
    .clk(clk), .rstn(rstn), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .NPCOp(npc_op), .IMM(imm), .RS_VAL(rs_val),
    .PC(pc), .PCPLUS4(pcplus4), .NPC(npc), .ras_empty(ras_empty), .ras_full(ras_full)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_npc();
    logic [W-1:0] p4;
    logic [W-1:0] off;
    p4  = pc_m + 32'd4;
    off = {{16{imm[15]}}, imm[15:0]};
    if (redirect) return redirect_pc;
    case (npc_op)
      3'd1:    return p4 + off * 32'd4;
      3'd2:    return (p4 & 32'hF000_0000) | ({6'd0, imm} * 32'd4);
      3'd3:    return rs_val;
      3'd4:    return (p4 & 32'hF000_0000) | ({6'd0, imm} * 32'd4);
      3'd5:    return (exp_q.size() > 0) ? exp_q[$] : rs_val;
      default: return p4;
    endcase
  endfunction

  always @(posedge clk or negedge rstn) begin
    logic [W-1:0] nxt;
    if (!rstn) begin
      pc_m = RPC;
      exp_q.delete();
    end else if (redirect) begin
      pc_m = redirect_pc;
    end else if (!stall) begin
      nxt = model_npc();
      if (npc_op == 3'd4) begin
        if (exp_q.size() == DEPTH) void'(exp_q.pop_front());
        exp_q.push_back(pc_m + 32'd4);
      end else if (npc_op == 3'd5 && exp_q.size() > 0) begin
        void'(exp_q.pop_back());
      end
      pc_m = nxt;
    end
  end

  // per-cycle compare on the falling edge
  always @(negedge clk) begin
    chk("pc",        pc,                 pc_m);
    chk("pcplus4",   pcplus4,            pc_m + 32'd4);
    chk("npc",       npc,                model_npc());
    chk("ras_empty", W'(ras_empty),      W'(exp_q.size() == 0));
    chk("ras_full",  W'(ras_full),       W'(exp_q.size() == DEPTH));
  end

  // driver tasks
  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic [2:0] op, input logic [25:0] im, input logic [W-1:0] rs,
                       input logic st, input logic rd, input logic [W-1:0] rp);
    npc_op = op; imm = im; rs_val = rs; stall = st; redirect = rd; redirect_pc = rp;
  endtask

  task automatic go_to(input logic [W-1:0] target);
    drive(3'd0, '0, '0, 1'b0, 1'b1, target);
    step();
    chk("redirect_pc", pc, target);
  endtask

  initial begin
    rstn = 1'b0;
    drive(3'd0, '0, '0, 1'b0, 1'b0, '0);
    repeat (3) step();
    chk("rst_pc", pc, RPC);
    chk("rst_empty", W'(ras_empty), 32'd1);
    chk("rst_full", W'(ras_full), 32'd0);
    rstn = 1'b1;
    #1;
    chk("rel_pc", pc, 32'h0040_0000);
    step();
    chk("seq_pc1", pc, 32'h0040_0004);
    step();
    chk("seq_pc2", pc, 32'h0040_0008);
    chk("seq_empty", W'(ras_empty), 32'd1);

    // branch / jump / jr
    go_to(32'h0040_0010);
    drive(3'd1, 26'h000FFFC, '0, 1'b0, 1'b0, '0);
    #1 chk("branch_npc", npc, 32'h0040_0004);
    drive(3'd2, 26'h0100000, '0, 1'b0, 1'b0, '0);
    #1 chk("jump_npc", npc, 32'h0040_0000);
    drive(3'd3, '0, 32'h1234_5678, 1'b0, 1'b0, '0);
    step();
    chk("jr_pc", pc, 32'h1234_5678);

    // call / return nest
    go_to(32'h0000_0100);
    drive(3'd4, 26'h800, '0, 1'b0, 1'b0, '0);
    step();
    chk("call1_pc", pc, 32'h0000_2000);
    go_to(32'h0000_0200);
    drive(3'd4, 26'hC00, '0, 1'b0, 1'b0, '0);
    step();
    chk("call2_pc", pc, 32'h0000_3000);
    drive(3'd5, '0, 32'h0BAD_0000, 1'b0, 1'b0, '0);
    step();
    chk("ret1_pc", pc, 32'h0000_0204);
    step();
    chk("ret2_pc", pc, 32'h0000_0104);
    chk("nest_empty", W'(ras_empty), 32'd1);

    // overflow / underflow: links 0x1004, 0x1104, ... 0x1404
    go_to(32'h0000_1000);
    for (int k = 0; k < 5; k++) begin
      drive(3'd4, 26'((32'h1100 + 32'h100 * k) >> 2), '0, 1'b0, 1'b0, '0);
      step();
      if (k == 3) chk("full_after4", W'(ras_full), 32'd1);
    end
    for (int k = 0; k < 5; k++) begin
      drive(3'd5, '0, 32'hDEAD_BEE0, 1'b0, 1'b0, '0);
      step();
      chk("ovf_ret", pc, (k < 4) ? (32'h1404 - 32'h100 * k) : 32'hDEAD_BEE0);
    end

    // stall / redirect
    go_to(32'h0000_0500);
    drive(3'd4, 26'h180, '0, 1'b0, 1'b0, '0);
    step();
    drive(3'd4, 26'h040, '0, 1'b1, 1'b0, '0);
    repeat (3) step();
    chk("stall_pc", pc, 32'h0000_0600);
    chk("stall_empty", W'(ras_empty), 32'd0);
    chk("stall_full", W'(ras_full), 32'd0);
    drive(3'd5, '0, 32'h0BAD_0000, 1'b1, 1'b1, 32'h8000_0000);
    step();
    chk("redir_pc", pc, 32'h8000_0000);
    drive(3'd5, '0, 32'h0BAD_0000, 1'b0, 1'b0, '0);
    #1 chk("redir_ret_npc", npc, 32'h0000_0504);
    step();
    chk("redir_ret_empty", W'(ras_empty), 32'd1);

    // async reset between edges
    drive(3'd4, 26'h180, '0, 1'b0, 1'b0, '0);
    repeat (2) step();
    rstn = 1'b0;
    #1;
    chk("arst_pc", pc, RPC);
    chk("arst_empty", W'(ras_empty), 32'd1);
    #1 rstn = 1'b1;
    drive(3'd0, '0, '0, 1'b0, 1'b0, '0);
    step();
    chk("arst_next_pc", pc, 32'h0040_0004);

    // random traffic
    for (int c = 0; c < 2000; c++) begin
      int r;
      r = $urandom_range(0, 9);
      drive((r >= 8) ? 3'd4 : (r >= 6) ? 3'd5 : 3'($urandom_range(0, 7)),
            26'($urandom), $urandom & 32'hFFFF_FFFC,
            ($urandom_range(0, 9) == 0), ($urandom_range(0, 19) == 0),
            $urandom & 32'hFFFF_FFFC);
      step();
      if ($urandom_range(0, 199) == 0) begin
        rstn = 1'b0;
        #1 rstn = 1'b1;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/npc_ras.md
# npc_ras

Registered program-counter unit with parametrised next-PC selection and a return-address stack (RAS). It holds the architectural PC, computes the next PC from a 3-bit operation code (sequential, branch, jump, jump-register, call, return), and applies it each clock unless stalled or redirected. It sits at the head of the fetch stage and drives the instruction-memory address directly.

## Interface
- `WIDTH`, 32: PC/address width; must be ≥ 28.
- `RESET_PC`, 0: PC value loaded on reset.
- `RAS_DEPTH`, 4: number of RAS entries; power of two, ≥ 2.
- `clk`  in  1  single clock, rising-edge.
- `rstn`  in  1  reset; asynchronous, active-low.
- `stall`  in  1  hold PC and RAS this cycle.
- `redirect`  in  1  force next PC to `redirect_pc`.
- `redirect_pc`  in  WIDTH  redirect target.
- `NPCOp`  in  3  next-PC operation (encoding below).
- `IMM`  in  26  instruction immediate field.
- `RS_VAL`  in  WIDTH  register operand for jump-register.
- `PC`  out  WIDTH  current PC (registered).
- `PCPLUS4`  out  WIDTH  PC + 4 (combinational).
- `NPC`  out  WIDTH  selected next PC (combinational).
- `ras_empty`  out  1  RAS holds 0 entries.
- `ras_full`  out  1  RAS holds RAS_DEPTH entries.

## Operation
- NPCOp encoding: 000 PLUS4 → PCPLUS4; 001 BRANCH → PCPLUS4 + sext(IMM[15:0])<<2; 010 JUMP → {PCPLUS4[WIDTH-1:28], IMM, 2'b00}; 011 JR → RS_VAL; 100 CALL → JUMP target, push PCPLUS4; 101 RET → RAS top, pop; 110/111 → PCPLUS4, no RAS effect.
- BRANCH means "taken"; the untaken case is issued as PLUS4 by the controller.
- All arithmetic modulo 2^WIDTH; sign extension to WIDTH bits.
- NPC priority: `redirect` → redirect_pc; else the NPCOp result. NPC is computed even while stalled.
- RAS: circular buffer of RAS_DEPTH entries, top pointer plus occupancy count (0..RAS_DEPTH).
- CALL while full: overwrite the oldest entry (pointer wraps); count stays RAS_DEPTH.
- RET while empty: NPC = RS_VAL (JR fallback); pointer/count unchanged.
- RET while non-empty: NPC = entry at top; pointer decrements (wrap), count −1. RS_VAL ignored.
- RAS is only modified on a clock edge where stall=0 and redirect=0.
- `redirect` never modifies the RAS; a pending CALL/RET in that cycle is discarded.

## Timing
- Reset (rstn=0, asynchronous): PC=RESET_PC, count=0, top pointer=0, all RAS entries=0; ras_empty=1, ras_full=0. NPC/PCPLUS4 follow combinationally from PC=RESET_PC.
- First rising edge after rstn deasserts: PC ← NPC (normal update).
- Edge with redirect=1: PC ← redirect_pc, regardless of stall.
- Edge with redirect=0, stall=1: PC, pointer, count and entries hold.
- Edge with redirect=0, stall=0: PC ← NPC; RAS push/pop per NPCOp takes effect on the same edge.
- Latency: NPC combinational from inputs (zero cycles); PC registered (one cycle).
- A RET on the cycle after a CALL returns the just-pushed value (no bypass needed; the push is visible after the edge).
- ras_empty/ras_full are decoded from the registered count; they change only on edges or reset.
- rstn asserted mid-stream clears the RAS regardless of stall/redirect.

## Test plan
- Reset: RESET_PC=0x0040_0000, hold rstn=0, then release with NPCOp=000 → PC=0x0040_0000, then 0x0040_0004, 0x0040_0008; ras_empty=1.
- Branch/jump: PC=0x0040_0010, BRANCH IMM[15:0]=0xFFFC → NPC=0x0040_0004; JUMP IMM=0x0100000 → NPC=0x0040_0000; JR RS_VAL=0x1234_5678 → PC=0x1234_5678.
- Call/return nest: CALL at PC=0x100 and 0x200 (targets elsewhere), then RET, RET → PCs 0x204, then 0x104; ras_empty=1 after the second RET.
- Overflow/underflow (RAS_DEPTH=4): 5 CALLs with link values A..E, then 5 RETs, RS_VAL=0xDEAD_BEE0 → returns E, D, C, B, then 0xDEAD_BEE0; ras_full=1 after the 4th CALL.
- Stall/redirect: stall=1 with CALL for 3 cycles → PC and count unchanged; redirect=1, stall=1, redirect_pc=0x8000_0000 with RET → PC=0x8000_0000, RAS count unchanged.
- Async reset mid-operation: after 2 CALLs, pulse rstn low between edges → PC=RESET_PC immediately, ras_empty=1 before the next edge.
